instruction_memory_loader: RTL

//  Writer side of the byte-addressed instruction memory. Accepts 32-bit instruction words over a

---
 rtl/instruction_memory_loader_pkg.sv | 13 +
 rtl/instruction_memory_loader_word_byte_serializer.sv | 14 +
 rtl/instruction_memory_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/instruction_memory_loader_pkg.sv
// Shared types for the instruction memory loader: FSM state encoding and byte-lane index width.
package instruction_memory_loader_pkg;

  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/instruction_memory_loader_word_byte_serializer.sv
// Selects one little-endian byte lane of a 32-bit word (lane 0 = bits [7:0]).
module word_byte_serializer
  import instruction_memory_loader_pkg::*;
(
  input  logic [31:0]      word,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       byte_out
);

  always_comb begin
    byte_out = word[8*idx +: 8];
  end

endmodule

// File: rtl/instruction_memory_loader.sv
// Accepts 32-bit words on a valid/ready stream and writes each as four little-endian byte
// writes into the instruction memory; flags end-of-program and capacity overflow.
module instruction_memory_loader
  import instruction_memory_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned MEM_BYTES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       word_in,
  input  logic              word_valid,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam logic [ADDR_W:0] CAPACITY = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] WORD_SZ  = (ADDR_W+1)'(4);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [31:0]        word_q, word_d;
  logic               last_q, last_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;

  logic [7:0]         lane_byte;
  logic [ADDR_W:0]    end_sum;

  word_byte_serializer u_ser (
    .word     (word_q),
    .idx      (idx_q),
    .byte_out (lane_byte)
  );

  // One extra bit so a pointer near the top of the address space cannot wrap past the check.
  assign end_sum = {1'b0, ptr_q} + WORD_SZ;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    word_d      = word_q;
    last_d      = last_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;
    word_ready  = (state_q == ST_WAIT);
    busy        = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d      = {base_addr[ADDR_W-1:2], 2'b00};
          overflow_d = 1'b0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (word_valid) begin
          word_d = word_in;
          last_d = word_last;
          if (end_sum > CAPACITY) begin
            overflow_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            idx_d   = '0;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = ptr_q;
        mem_wdata_d = lane_byte;
        ptr_d       = ptr_q + 1'b1;
        idx_d       = idx_q + 1'b1;
        if (idx_q == '1) begin
          state_d = last_q ? ST_DONE : ST_WAIT;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      ptr_q       <= '0;
      word_q      <= '0;
      last_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      word_q      <= word_d;
      last_q      <= last_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule
